// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared types and defaults for the fetch / branch control slice.
//   br_type_e        : branch type encoding carried on br_type
//   pc_state_e       : fetch FSM state encoding
//   DEFAULT_RESET_PC : PC value loaded on reset unless overridden
//   DEFAULT_PC_STEP  : PC increment per consumed instruction (word addressing)
package cpu_pkg;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;
    localparam logic [15:0] DEFAULT_PC_STEP  = 16'd1;

    typedef enum logic [1:0] {
        BR_JMP  = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_RSVD = 2'b11
    } br_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        ISSUE = 2'd3
    } pc_state_e;

endpackage

// File: rtl/pc_branch_ctrl_if.sv
// pc_branch_ctrl_if -- instruction memory fetch bus.
//   imem_req   : single-cycle fetch request (controller -> memory)
//   imem_addr  : fetch address, valid while imem_req is high
//   imem_valid : fetch response strobe (memory -> controller)
//   imem_rdata : fetched instruction, qualified by imem_valid
// modport master : fetch controller side
// modport slave  : instruction memory side
interface pc_branch_ctrl_if;

    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );

endinterface

// File: rtl/branch_cond.sv
// branch_cond -- combinational branch condition evaluation.
//   br_type   : branch type (JMP / BEQ / BNE / reserved)
//   zero_flag : registered Zero flag
//   taken     : branch redirects the PC
//   illegal   : reserved encoding; never taken
module branch_cond
    import cpu_pkg::*;
(
    input  br_type_e br_type,
    input  logic     zero_flag,
    output logic     taken,
    output logic     illegal
);

    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (br_type)
            BR_JMP:  taken   = 1'b1;
            BR_BEQ:  taken   = zero_flag;
            BR_BNE:  taken   = !zero_flag;
            BR_RSVD: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl -- program counter, instruction fetch and branch redirect.
//   clk, reset        : clock; asynchronous active-high reset
//   zero_flag         : registered Zero flag
//   zero_flag_enable  : flag register is being written this cycle
//   imem              : fetch bus (master side)
//   instr_valid/ready : instruction handoff to decode, instr_out its payload
//   br_valid/ready    : branch request from decode (br_type, br_target)
//   br_done/taken/err : one-cycle branch result pulses
//   flush             : one-cycle pulse after a taken branch
//   pc                : current program counter
module pc_branch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [15:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    zero_flag,
    input  logic                    zero_flag_enable,
    pc_branch_ctrl_if.master        imem,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [15:0]             instr_out,
    input  logic                    br_valid,
    output logic                    br_ready,
    input  logic [1:0]              br_type,
    input  logic [15:0]             br_target,
    output logic                    br_done,
    output logic                    br_taken,
    output logic                    br_err,
    output logic                    flush,
    output logic [15:0]             pc
);

    pc_state_e   state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic        discard_q, discard_d;
    logic        br_done_q, br_taken_q, br_err_q, flush_q;

    logic        cond_taken;
    logic        cond_illegal;
    logic        br_fire;
    logic        redirect;

    branch_cond u_branch_cond (
        .br_type   (br_type_e'(br_type)),
        .zero_flag (zero_flag),
        .taken     (cond_taken),
        .illegal   (cond_illegal)
    );

    // A branch must not see a flag that is being rewritten this cycle, and a
    // second redirect cannot be tracked while a stale response is pending.
    assign br_ready = !zero_flag_enable && !discard_q;
    assign br_fire  = br_valid && br_ready;
    assign redirect = br_fire && cond_taken;

    assign imem.imem_req  = (state_q == FETCH);
    assign imem.imem_addr = pc_q;
    assign instr_valid    = (state_q == ISSUE);
    assign instr_out      = instr_q;
    assign pc             = pc_q;
    assign br_done        = br_done_q;
    assign br_taken       = br_taken_q;
    assign br_err         = br_err_q;
    assign flush          = flush_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        discard_d = discard_q;

        case (state_q)
            IDLE: state_d = FETCH;

            FETCH: begin
                // The request for the old pc still goes out this cycle; its
                // response must be dropped if we are redirecting.
                state_d = WAIT;
                if (redirect) discard_d = 1'b1;
            end

            WAIT: begin
                if (imem.imem_valid) begin
                    if (discard_q || redirect) begin
                        state_d   = FETCH;
                        discard_d = 1'b0;
                    end else begin
                        instr_d = imem.imem_rdata;
                        state_d = ISSUE;
                    end
                end else if (redirect) begin
                    discard_d = 1'b1;
                end
            end

            ISSUE: begin
                // A handshake in the same cycle as a redirect still consumes
                // the instruction, but the target wins over the increment.
                if (redirect) begin
                    state_d = FETCH;
                end else if (instr_ready) begin
                    state_d = FETCH;
                    pc_d    = pc_q + PC_STEP;
                end
            end

            default: state_d = IDLE;
        endcase

        if (redirect) pc_d = br_target;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before this edge, independent of order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 16'h0000;
            discard_q  <= 1'b0;
            br_done_q  <= 1'b0;
            br_taken_q <= 1'b0;
            br_err_q   <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            discard_q  <= discard_d;
            br_done_q  <= br_fire;
            br_taken_q <= br_fire && cond_taken;
            br_err_q   <= br_fire && cond_illegal;
            flush_q    <= redirect;
        end
    end

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// tb_pc_branch_ctrl -- directed bench for pc_branch_ctrl.
// A per-cycle vector table covers reset-out, sequential fetch, BEQ taken,
// BNE not taken, the flag hazard and the reserved type; hand-written
// sequences cover the WAIT discard, redirect-vs-increment priority, PC wrap
// and reset during an outstanding fetch.
module tb_pc_branch_ctrl;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        zero_flag;
    logic        zero_flag_enable;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_out;
    logic        br_valid;
    logic        br_ready;
    logic [1:0]  br_type;
    logic [15:0] br_target;
    logic        br_done;
    logic        br_taken;
    logic        br_err;
    logic        flush;
    logic [15:0] pc;

    pc_branch_ctrl_if imem_if ();

    pc_branch_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .zero_flag        (zero_flag),
        .zero_flag_enable (zero_flag_enable),
        .imem             (imem_if),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr_out        (instr_out),
        .br_valid         (br_valid),
        .br_ready         (br_ready),
        .br_type          (br_type),
        .br_target        (br_target),
        .br_done          (br_done),
        .br_taken         (br_taken),
        .br_err           (br_err),
        .flush            (flush),
        .pc               (pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    // Memory model: a request seen in cycle k answers in cycle k+mem_lat.
    // Response data is fixed at request time, so a salt change only affects
    // later requests.
    int          mem_lat  = 1;
    logic [15:0] mem_salt = 16'h0000;
    bit          pend     = 1'b0;
    int          pend_cnt = 0;
    logic [15:0] pend_data;

    initial begin
        imem_if.imem_valid = 1'b0;
        imem_if.imem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            imem_if.imem_valid = 1'b0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    imem_if.imem_valid = 1'b1;
                    imem_if.imem_rdata = pend_data;
                    pend = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (!reset && imem_if.imem_req === 1'b1) begin
                pend      = 1'b1;
                pend_data = mem_word(imem_if.imem_addr) ^ mem_salt;
                pend_cnt  = mem_lat - 1;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        ir;
        logic        bv;
        logic [1:0]  bt;
        logic [15:0] tgt;
        logic        zf;
        logic        zfe;
        logic        req;
        logic [15:0] pc;
        logic        iv;
        logic        rdy;
        logic        done;
        logic        tk;
        logic        err;
        logic        fl;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic ir, input logic bv, input logic [1:0] bt, input logic [15:0] tgt,
        input logic zf, input logic zfe,
        input logic req, input logic [15:0] xpc, input logic iv, input logic rdy,
        input logic done, input logic tk, input logic err, input logic fl);
        vec_t v;
        v.ir = ir; v.bv = bv; v.bt = bt; v.tgt = tgt; v.zf = zf; v.zfe = zfe;
        v.req = req; v.pc = xpc; v.iv = iv; v.rdy = rdy;
        v.done = done; v.tk = tk; v.err = err; v.fl = fl;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_issue(input string name);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            @(negedge clk);
            if (instr_valid === 1'b1) found = 1'b1;
        end
        check({name, ".issue_reached"}, {31'd0, found}, 32'd1);
    endtask

    initial begin
        // Cycle-by-cycle vectors starting from the first cycle out of reset.
        //               ir bv bt     tgt       zf zfe  req pc        iv rdy dn tk er fl
        vecs[0]  = mk(1, 0, 2'b00, 16'h0000, 0, 0,   0, 16'h0000, 0, 1,  0, 0, 0, 0); // IDLE
        vecs[1]  = mk(1, 0, 2'b00, 16'h0000, 0, 0,   1, 16'h0000, 0, 1,  0, 0, 0, 0); // fetch 0
        vecs[2]  = mk(1, 0, 2'b00, 16'h0000, 0, 0,   0, 16'h0000, 0, 1,  0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 2'b00, 16'h0000, 0, 0,   0, 16'h0000, 1, 1,  0, 0, 0, 0);
        vecs[4]  = mk(1, 0, 2'b00, 16'h0000, 0, 0,   1, 16'h0001, 0, 1,  0, 0, 0, 0); // fetch 1
        vecs[5]  = mk(1, 0, 2'b00, 16'h0000, 0, 0,   0, 16'h0001, 0, 1,  0, 0, 0, 0);
        vecs[6]  = mk(1, 0, 2'b00, 16'h0000, 0, 0,   0, 16'h0001, 1, 1,  0, 0, 0, 0);
        vecs[7]  = mk(1, 0, 2'b00, 16'h0000, 0, 0,   1, 16'h0002, 0, 1,  0, 0, 0, 0); // fetch 2
        vecs[8]  = mk(1, 0, 2'b00, 16'h0000, 0, 0,   0, 16'h0002, 0, 1,  0, 0, 0, 0);
        vecs[9]  = mk(0, 1, 2'b01, 16'h0040, 1, 0,   0, 16'h0002, 1, 1,  0, 0, 0, 0); // BEQ in ISSUE
        vecs[10] = mk(1, 0, 2'b00, 16'h0000, 0, 0,   1, 16'h0040, 0, 1,  1, 1, 0, 1); // flush, fetch 40
        vecs[11] = mk(1, 0, 2'b00, 16'h0000, 0, 0,   0, 16'h0040, 0, 1,  0, 0, 0, 0);
        vecs[12] = mk(0, 0, 2'b00, 16'h0000, 0, 0,   0, 16'h0040, 1, 1,  0, 0, 0, 0); // decode stalls
        vecs[13] = mk(1, 0, 2'b00, 16'h0000, 0, 0,   0, 16'h0040, 1, 1,  0, 0, 0, 0);
        vecs[14] = mk(1, 1, 2'b10, 16'h0080, 1, 0,   1, 16'h0041, 0, 1,  0, 0, 0, 0); // BNE, Z=1
        vecs[15] = mk(1, 0, 2'b00, 16'h0000, 0, 0,   0, 16'h0041, 0, 1,  1, 0, 0, 0); // done, not taken
        vecs[16] = mk(1, 0, 2'b00, 16'h0000, 0, 0,   0, 16'h0041, 1, 1,  0, 0, 0, 0);
        vecs[17] = mk(1, 1, 2'b01, 16'h0200, 0, 1,   1, 16'h0042, 0, 0,  0, 0, 0, 0); // flag busy
        vecs[18] = mk(1, 1, 2'b01, 16'h0200, 1, 0,   0, 16'h0042, 0, 1,  0, 0, 0, 0); // accept + imem_valid
        vecs[19] = mk(1, 0, 2'b00, 16'h0000, 0, 0,   1, 16'h0200, 0, 1,  1, 1, 0, 1);
        vecs[20] = mk(1, 0, 2'b00, 16'h0000, 0, 0,   0, 16'h0200, 0, 1,  0, 0, 0, 0);
        vecs[21] = mk(1, 0, 2'b00, 16'h0000, 0, 0,   0, 16'h0200, 1, 1,  0, 0, 0, 0);
        vecs[22] = mk(1, 1, 2'b11, 16'h0300, 0, 0,   1, 16'h0201, 0, 1,  0, 0, 0, 0); // reserved type
        vecs[23] = mk(1, 0, 2'b00, 16'h0000, 0, 0,   0, 16'h0201, 0, 1,  1, 0, 1, 0);
        vecs[24] = mk(1, 0, 2'b00, 16'h0000, 0, 0,   0, 16'h0201, 1, 1,  0, 0, 0, 0);

        reset            = 1'b1;
        zero_flag        = 1'b0;
        zero_flag_enable = 1'b0;
        instr_ready      = 1'b1;
        br_valid         = 1'b0;
        br_type          = 2'b00;
        br_target        = 16'h0000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.pc",          {16'd0, pc},               {16'd0, DEFAULT_RESET_PC});
        check("rst.instr_out",   {16'd0, instr_out},        32'h0);
        check("rst.imem_req",    {31'd0, imem_if.imem_req}, 32'h0);
        check("rst.instr_valid", {31'd0, instr_valid},      32'h0);
        check("rst.pulses",      {28'd0, br_done, br_taken, br_err, flush}, 32'h0);

        step();
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if (i > 0) step();
            instr_ready      = vecs[i].ir;
            br_valid         = vecs[i].bv;
            br_type          = vecs[i].bt;
            br_target        = vecs[i].tgt;
            zero_flag        = vecs[i].zf;
            zero_flag_enable = vecs[i].zfe;
            @(negedge clk);
            check($sformatf("v%0d.imem_req", i),    {31'd0, imem_if.imem_req}, {31'd0, vecs[i].req});
            check($sformatf("v%0d.pc", i),          {16'd0, pc},               {16'd0, vecs[i].pc});
            if (vecs[i].req)
                check($sformatf("v%0d.imem_addr", i), {16'd0, imem_if.imem_addr}, {16'd0, vecs[i].pc});
            check($sformatf("v%0d.instr_valid", i), {31'd0, instr_valid},      {31'd0, vecs[i].iv});
            if (vecs[i].iv)
                check($sformatf("v%0d.instr_out", i), {16'd0, instr_out}, {16'd0, mem_word(vecs[i].pc)});
            check($sformatf("v%0d.br_ready", i),    {31'd0, br_ready},         {31'd0, vecs[i].rdy});
            check($sformatf("v%0d.br_done", i),     {31'd0, br_done},          {31'd0, vecs[i].done});
            check($sformatf("v%0d.br_taken", i),    {31'd0, br_taken},         {31'd0, vecs[i].tk});
            check($sformatf("v%0d.br_err", i),      {31'd0, br_err},           {31'd0, vecs[i].err});
            check($sformatf("v%0d.flush", i),       {31'd0, flush},            {31'd0, vecs[i].fl});
        end

        // JMP while waiting on a slow fetch; the stale response arrives three
        // cycles after the branch and must never reach instr_out.
        mem_lat = 4;
        step();                                   // FETCH 0x0202
        @(negedge clk);
        check("disc.fetch_req",  {31'd0, imem_if.imem_req},  32'h1);
        check("disc.fetch_addr", {16'd0, imem_if.imem_addr}, 32'h0202);
        step();                                   // WAIT
        br_valid    = 1'b1;
        br_type     = BR_JMP;
        br_target   = 16'h0100;
        instr_ready = 1'b0;
        @(negedge clk);
        check("disc.br_ready_wait", {31'd0, br_ready}, 32'h1);
        step();
        br_valid = 1'b0;
        @(negedge clk);
        check("disc.br_done",   {31'd0, br_done},  32'h1);
        check("disc.br_taken",  {31'd0, br_taken}, 32'h1);
        check("disc.flush",     {31'd0, flush},    32'h1);
        check("disc.pc",        {16'd0, pc},       32'h0100);
        check("disc.ready_low", {31'd0, br_ready}, 32'h0);
        check("disc.no_req",    {31'd0, imem_if.imem_req}, 32'h0);
        step();
        @(negedge clk);
        check("disc.ready_low2", {31'd0, br_ready},    32'h0);
        check("disc.no_issue",   {31'd0, instr_valid}, 32'h0);
        step();                                   // stale response arrives
        @(negedge clk);
        check("disc.dropped",    {31'd0, instr_valid}, 32'h0);
        mem_lat = 1;
        step();
        @(negedge clk);
        check("disc.refetch_req",  {31'd0, imem_if.imem_req},  32'h1);
        check("disc.refetch_addr", {16'd0, imem_if.imem_addr}, 32'h0100);
        check("disc.ready_back",   {31'd0, br_ready},          32'h1);
        wait_issue("disc");
        check("disc.instr_out", {16'd0, instr_out}, {16'd0, mem_word(16'h0100)});

        // Redirect and handshake in the same ISSUE cycle: target wins.
        step();
        instr_ready = 1'b1;
        br_valid    = 1'b1;
        br_type     = BR_JMP;
        br_target   = 16'hFFFF;
        @(negedge clk);
        check("prio.instr_held", {16'd0, instr_out}, {16'd0, mem_word(16'h0100)});
        step();
        br_valid = 1'b0;
        @(negedge clk);
        check("prio.pc",    {16'd0, pc},               32'hFFFF);
        check("prio.req",   {31'd0, imem_if.imem_req}, 32'h1);
        check("prio.flush", {31'd0, flush},            32'h1);
        step();                                   // WAIT
        step();                                   // ISSUE, consumed
        @(negedge clk);
        check("wrap.instr_valid", {31'd0, instr_valid}, 32'h1);
        check("wrap.instr_out",   {16'd0, instr_out},   {16'd0, mem_word(16'hFFFF)});
        mem_lat = 2;
        step();
        @(negedge clk);
        check("wrap.pc",   {16'd0, pc},                32'h0000);
        check("wrap.addr", {16'd0, imem_if.imem_addr}, 32'h0000);

        // Reset while the fetch of 0x0000 is outstanding; its response lands
        // in IDLE and must be ignored.
        step();
        reset = 1'b1;
        @(negedge clk);
        check("mrst.pc",          {16'd0, pc},               32'h0000);
        check("mrst.instr_out",   {16'd0, instr_out},        32'h0000);
        check("mrst.instr_valid", {31'd0, instr_valid},      32'h0);
        check("mrst.imem_req",    {31'd0, imem_if.imem_req}, 32'h0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("mrst.idle_req", {31'd0, imem_if.imem_req}, 32'h0);
        check("mrst.idle_iv",  {31'd0, instr_valid},      32'h0);
        mem_lat  = 1;
        mem_salt = 16'h0F0F;
        step();
        @(negedge clk);
        check("mrst.fetch_req",  {31'd0, imem_if.imem_req},  32'h1);
        check("mrst.fetch_addr", {16'd0, imem_if.imem_addr}, 32'h0000);
        wait_issue("mrst");
        check("mrst.instr_out", {16'd0, instr_out}, {16'd0, mem_word(16'h0000) ^ 16'h0F0F});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_branch_ctrl.md
PC_BRANCH_CTRL -- requirements
Module: pc_branch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 SHALL have parameter PC_STEP, default 16'd1, increment applied per consumed instruction (word addressing).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high.
REQ-005 SHALL have port zero_flag  input  1  registered Zero flag from the flag register.
REQ-006 SHALL have port zero_flag_enable  input  1  flag register updates at the next edge (flag busy).
REQ-007 SHALL have port imem_req  output  1  single-cycle fetch request.
REQ-008 SHALL have port imem_addr  output  16  fetch address, equal to pc while imem_req is high.
REQ-009 SHALL have port imem_valid  input  1  fetch response strobe, at least 1 cycle after imem_req.
REQ-010 SHALL have port imem_rdata  input  16  fetched instruction, qualified by imem_valid.
REQ-011 SHALL have port instr_valid / instr_ready  output / input  1 / 1  instruction handoff to decode.
REQ-012 SHALL have port instr_out  output  16  instruction held stable while instr_valid is high and instr_ready is low.
REQ-013 SHALL have port br_valid / br_ready  input / output  1 / 1  branch request handshake from decode.
REQ-014 SHALL have port br_type  input  2  00 JMP, 01 BEQ, 10 BNE, 11 reserved.
REQ-015 SHALL have port br_target  input  16  absolute branch target.
REQ-016 SHALL have ports br_done, br_taken, br_err, flush  output  1 each  one-cycle result pulses.
REQ-017 SHALL have port pc  output  16  current program counter.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, WAIT, ISSUE.
- IDLE->FETCH unconditionally.
- FETCH: assert imem_req with imem_addr=pc, then go to WAIT.
- WAIT->ISSUE on imem_valid, capturing imem_rdata into instr_out.
- ISSUE->FETCH on instr_valid&&instr_ready, with pc<=pc+PC_STEP (modulo 2^16, 16'hFFFF+1=16'h0000).
REQ-019 SHALL drive instr_valid high only in ISSUE.
REQ-020 SHALL hold br_ready = !zero_flag_enable, so a branch is never evaluated against a flag being written that cycle.
REQ-021 SHALL accept a branch on br_valid&&br_ready.
- Taken when JMP, BEQ with zero_flag=1, or BNE with zero_flag=0.
- Type 11 SHALL be not taken and pulse br_err.
REQ-022 SHALL pulse br_done the cycle after acceptance, with br_taken valid alongside it.
REQ-023 SHALL apply a taken branch as follows: pc<=br_target and flush pulses the next cycle.
- In ISSUE: instr_valid drops and the FSM goes to FETCH.
- In FETCH: the request issues with the old pc, a discard bit is set, and the FSM goes to WAIT.
- In WAIT: a discard bit is set; the next imem_valid is dropped and the FSM goes to FETCH with the target.
REQ-024 SHALL give a taken-branch redirect priority over the pc increment when both occur in the same cycle in ISSUE.
- The handshaked instruction counts as consumed.
- pc becomes br_target, not pc+PC_STEP.
REQ-025 SHALL discard imem_valid arriving in the same cycle as a taken-branch acceptance in WAIT, and go to FETCH with br_target.
REQ-026 SHALL make a not-taken branch change neither pc nor FSM state, and SHALL NOT pulse flush.
REQ-027 SHALL ignore imem_valid in IDLE, FETCH and ISSUE.
REQ-028 SHALL NOT accept a second branch while the discard bit is set; br_ready is low during that time.

Reset
REQ-029 SHALL on reset set state=IDLE, pc=RESET_PC, instr_out=16'h0000, discard=0, and deassert all pulse outputs, imem_req and instr_valid.
REQ-030 SHALL on reset asserted mid-fetch drop any later response through IDLE (REQ-027).

Structure
REQ-031 SHALL place the br_type encodings, the FSM state enum and the default RESET_PC in a shared package cpu_pkg.
REQ-032 SHALL put taken/not-taken evaluation in one combinational sub-module, branch_cond (inputs br_type and zero_flag; outputs taken and illegal).

Verification
REQ-033 SHALL verify reset: release reset -> imem_req at cycle 2 with imem_addr=16'h0000; then 3 fetches with 1-cycle latency -> imem_addr 0,1,2.
REQ-034 SHALL verify BEQ taken: BEQ, target=16'h0040, zero_flag=1 -> br_taken=1, flush pulse, next imem_addr=16'h0040.
REQ-035 SHALL verify BNE not taken: BNE with zero_flag=1 -> br_done=1, br_taken=0, no flush, pc continues sequentially.
REQ-036 SHALL verify flag hazard: br_valid with zero_flag_enable=1 -> br_ready=0 that cycle; accepted next cycle using the updated zero_flag.
REQ-037 SHALL verify discard: JMP to 16'h0100 while in WAIT, with imem_valid 3 cycles later -> that rdata never appears on instr_out; next imem_addr=16'h0100.
REQ-038 SHALL verify wrap and reserved type: pc=16'hFFFF consumed -> pc=16'h0000; br_type=11 -> br_err pulse and pc unchanged.
